// File: rtl/m_mem_arbiter.sv
// -----------------------------------------------------------------------------
// m_mem_arbiter
//
// Three-way arbiter in front of a single-port DRAM controller. The page
// walker (pw), instruction fetch (if) and data (dt) requesters share one
// DRAM port. At most one DRAM transaction is in flight.
//
// The FSM runs IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE  : sample requests, pick a winner, latch its command.
//   ISSUE : one-cycle grant to the winner plus one DRAM strobe.
//   WAIT  : hold while the DRAM reports busy, then capture its read data.
//   RESP  : one-cycle completion pulse to the owner.
//
// Priority: pw always wins. An if/dt tie goes to if, unless MEM_ARB_RR_EN
// is defined. In that case the tie alternates using a pointer that is
// updated only on if/dt grants.
//
// Optional feature macro: MEM_ARB_RR_EN (round-robin if/dt tie-break).
//
// Ports
//   CLK, RST                    clock, synchronous active-high reset
//   w_pw_req/we/addr/wdata      page-walker PTE read/write request
//   w_if_req/addr               instruction-fetch read request
//   w_dt_req/we/addr/wdata      data load/store request
//   w_{pw,if,dt}_gnt            grant pulse (ISSUE cycle)
//   w_{pw,if,dt}_done           completion pulse (RESP cycle)
//   w_rdata                     last captured DRAM read data
//   w_owner                     0 none, 1 pw, 2 if, 3 dt
//   w_dram_le/we/addr/wdata     DRAM command (valid only on a strobe)
//   w_dram_busy, w_dram_odata   DRAM status and read data
// -----------------------------------------------------------------------------
module m_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              w_pw_req,
    input  logic              w_pw_we,
    input  logic [ADDR_W-1:0] w_pw_addr,
    input  logic [DATA_W-1:0] w_pw_wdata,

    input  logic              w_if_req,
    input  logic [ADDR_W-1:0] w_if_addr,

    input  logic              w_dt_req,
    input  logic              w_dt_we,
    input  logic [ADDR_W-1:0] w_dt_addr,
    input  logic [DATA_W-1:0] w_dt_wdata,

    output logic              w_pw_gnt,
    output logic              w_if_gnt,
    output logic              w_dt_gnt,
    output logic              w_pw_done,
    output logic              w_if_done,
    output logic              w_dt_done,
    output logic [DATA_W-1:0] w_rdata,
    output logic [1:0]        w_owner,

    output logic              w_dram_le,
    output logic              w_dram_we,
    output logic [ADDR_W-1:0] w_dram_addr,
    output logic [DATA_W-1:0] w_dram_wdata,
    input  logic              w_dram_busy,
    input  logic [DATA_W-1:0] w_dram_odata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_PW   = 2'd1;
    localparam logic [1:0] OWN_IF   = 2'd2;
    localparam logic [1:0] OWN_DT   = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;

    // Winner of the current IDLE cycle (combinational)
    logic [1:0]        win_owner;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_we;
    logic              tie_to_dt;
    logic              start;

`ifdef MEM_ARB_RR_EN
    // 0: next if/dt tie goes to if, 1: next tie goes to dt
    logic rr_ptr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr <= 1'b0;
        end else if (start && win_owner == OWN_IF) begin
            rr_ptr <= 1'b1;
        end else if (start && win_owner == OWN_DT) begin
            rr_ptr <= 1'b0;
        end
    end

    assign tie_to_dt = rr_ptr;
`else
    assign tie_to_dt = 1'b0;
`endif

    // NOTE: every signal gets a default at the top of the block, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        win_owner = OWN_NONE;
        win_addr  = '0;
        win_wdata = '0;
        win_we    = 1'b0;
        if (w_pw_req) begin
            win_owner = OWN_PW;
            win_addr  = w_pw_addr;
            win_we    = w_pw_we;
            win_wdata = w_pw_we ? w_pw_wdata : '0;
        end else if (w_dt_req && (!w_if_req || tie_to_dt)) begin
            win_owner = OWN_DT;
            win_addr  = w_dt_addr;
            win_we    = w_dt_we;
            win_wdata = w_dt_we ? w_dt_wdata : '0;
        end else if (w_if_req) begin
            // Instruction fetch is always a read
            win_owner = OWN_IF;
            win_addr  = w_if_addr;
        end
    end

    assign start = (state == ST_IDLE) && (win_owner != OWN_NONE) && !w_dram_busy;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values that held before the clock edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            w_owner   <= OWN_NONE;
            w_rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lat_addr  <= win_addr;
                        lat_wdata <= win_wdata;
                        lat_we    <= win_we;
                        w_owner   <= win_owner;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Capture on every completion, writes included, so that
                    // w_rdata always reflects the last DRAM response.
                    if (!w_dram_busy) begin
                        w_rdata <= w_dram_odata;
                        state   <= ST_RESP;
                    end
                end
                default: begin  // ST_RESP
                    lat_addr  <= '0;
                    lat_wdata <= '0;
                    lat_we    <= 1'b0;
                    w_owner   <= OWN_NONE;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    logic in_issue;
    logic in_resp;

    assign in_issue = (state == ST_ISSUE);
    assign in_resp  = (state == ST_RESP);

    assign w_pw_gnt  = in_issue && (w_owner == OWN_PW);
    assign w_if_gnt  = in_issue && (w_owner == OWN_IF);
    assign w_dt_gnt  = in_issue && (w_owner == OWN_DT);

    assign w_pw_done = in_resp && (w_owner == OWN_PW);
    assign w_if_done = in_resp && (w_owner == OWN_IF);
    assign w_dt_done = in_resp && (w_owner == OWN_DT);

    // The address and data buses are driven only while a strobe is up
    assign w_dram_le    = in_issue && !lat_we;
    assign w_dram_we    = in_issue &&  lat_we;
    assign w_dram_addr  = in_issue ? lat_addr  : '0;
    assign w_dram_wdata = in_issue ? lat_wdata : '0;

endmodule

// File: doc/m_mem_arbiter.md
M_MEM_ARBITER -- requirements
Module: m_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width of all requester and DRAM address ports.
REQ-002 SHALL have parameter DATA_W, default 32, width of all write-data and read-data ports.
REQ-003 SHALL have port CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports w_pw_req in 1, w_pw_we in 1, w_pw_addr in ADDR_W, w_pw_wdata in DATA_W: page-walker PTE read/write request.
REQ-006 SHALL have ports w_if_req in 1, w_if_addr in ADDR_W: instruction-fetch read request.
REQ-007 SHALL have ports w_dt_req in 1, w_dt_we in 1, w_dt_addr in ADDR_W, w_dt_wdata in DATA_W: data load/store request.
REQ-008 SHALL have per-requester outputs w_pw_gnt, w_if_gnt, w_dt_gnt (1 each, grant pulse) and w_pw_done, w_if_done, w_dt_done (1 each, completion pulse).
REQ-009 SHALL have output w_rdata  out  DATA_W: read data, valid while a done is high.
REQ-010 SHALL have output w_owner  out  2: 0 none, 1 pw, 2 if, 3 dt.
REQ-011 SHALL have DRAM-side ports w_dram_le out 1, w_dram_we out 1, w_dram_addr out ADDR_W, w_dram_wdata out DATA_W, w_dram_busy in 1, w_dram_odata in DATA_W.

Function
REQ-012 SHALL implement FSM IDLE(0), ISSUE(1), WAIT(2), RESP(3); one DRAM transaction in flight at most.
REQ-013 IDLE: when any req is high and w_dram_busy is low, SHALL select a winner, latch its addr/we/wdata/owner and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-014 Priority SHALL be pw over if/dt, always; pw is never starved.
REQ-015 ISSUE: SHALL assert the winner's gnt and exactly one of w_dram_le (read) or w_dram_we (write) for one cycle with latched addr/wdata, then go to WAIT.
REQ-016 WAIT: SHALL stay while w_dram_busy is high; on the first cycle with w_dram_busy low, SHALL capture w_dram_odata into w_rdata and go to RESP. WAIT SHALL last at least one cycle.
REQ-017 RESP: SHALL assert the owner's done for one cycle, then go to IDLE; w_owner returns to 0 in IDLE.
REQ-018 Requests SHALL be sampled only in IDLE; a requester holds req until its gnt and drops it the cycle after gnt; req high outside IDLE SHALL be ignored.
REQ-019 Minimum latency: req in IDLE -> done SHALL be 4 cycles (IDLE, ISSUE, WAIT, RESP) when busy never rises.
REQ-020 w_rdata SHALL hold its value until the next capture; for writes it SHALL still capture w_dram_odata (value don't-care).
REQ-021 w_if_req addresses SHALL always issue as reads (we=0).
REQ-022 w_dram_addr/w_dram_wdata SHALL be 0 whenever le and we are both low.

Reset
REQ-023 RST high at an edge SHALL force IDLE, clear latched request, w_rdata=0, w_owner=0, all gnt/done/le/we=0, round-robin pointer to "if". This applies mid-transaction; the in-flight DRAM access is abandoned and no done is issued.

Configuration
REQ-024 Macro MEM_ARB_RR_EN defined: if/dt tie (both high, pw low) SHALL alternate; a pointer flips to the other requester after each if or dt grant; pw grants leave the pointer unchanged.
REQ-025 MEM_ARB_RR_EN undefined: tie SHALL always go to if; no pointer register.

Verification
REQ-026 pw_req=1 we=0 addr=0x1000, if_req=1, dt_req=1 same cycle, busy=0 -> pw_gnt in cycle 2, dram_le=1 addr=0x1000, pw_done cycle 4, owner=1.
REQ-027 dt_req we=1 addr=0x2004 wdata=0xDEADBEEF, busy high 3 cycles after ISSUE -> dram_we=1 one cycle, WAIT 3 cycles, dt_done one cycle later.
REQ-028 if and dt held continuously, 4 transactions: RR_EN -> order if,dt,if,dt; undefined -> if,if,if,if.
REQ-029 if read, dram_odata=0x12345678 when busy falls -> w_rdata=0x12345678 with if_done, held after.
REQ-030 RST asserted during WAIT -> next cycle IDLE, all outputs 0, no done; subsequent pw request completes normally.
